osd_font_edge: RTL and testbench



---
 rtl/osd_font_edge_pkg.sv | 119 +++++++++++
 rtl/osd_font_edge_if.sv | 15 +
 rtl/osd_font_edge_sync.sv | 33 +++
 rtl/osd_font_edge.sv | 47 ++++
 tb/tb_osd_font_edge.sv | 139 +++++++++++++
 5 files changed

// File: rtl/osd_font_edge_pkg.sv
// Shared constants and the built-in 8x16 glyph table for the debug text overlay.
// Rows are packed top row first, so row 0 is the most significant byte.
package osd_pkg;

    localparam int FONT_ADDR_BITS = 11;
    localparam int FONT_DATA_BITS = 8;
    localparam int FONT_ROWS      = 16;
    localparam int FONT_COLS      = 8;
    localparam logic [7:0] FONT_FIRST_PRINTABLE = 8'h20;
    localparam logic [7:0] FONT_LAST_PRINTABLE  = 8'h7E;

    typedef logic [FONT_ROWS*FONT_COLS-1:0] glyph_t;

    function automatic glyph_t font_glyph(input logic [6:0] code);
        glyph_t g;
        g = '0;
        if ({1'b0, code} >= FONT_FIRST_PRINTABLE && {1'b0, code} <= FONT_LAST_PRINTABLE) begin
            case (code)
                7'h21: g = 128'h0000183c_3c3c1818_18001818_00000000;
                7'h22: g = 128'h00666666_24000000_00000000_00000000;
                7'h23: g = 128'h0000006c_6cfe6c6c_6cfe6c6c_00000000;
                7'h24: g = 128'h18187cc6_c2c07c06_0686c67c_18180000;
                7'h25: g = 128'h00000000_c2c60c18_3060c686_00000000;
                7'h26: g = 128'h0000386c_6c3876dc_cccccc76_00000000;
                7'h27: g = 128'h00303030_60000000_00000000_00000000;
                7'h28: g = 128'h00000c18_30303030_3030180c_00000000;
                7'h29: g = 128'h00003018_0c0c0c0c_0c0c1830_00000000;
                7'h2a: g = 128'h00000000_00663cff_3c660000_00000000;
                7'h2b: g = 128'h00000000_0018187e_18180000_00000000;
                7'h2c: g = 128'h00000000_00000000_00181818_30000000;
                7'h2d: g = 128'h00000000_000000fe_00000000_00000000;
                7'h2e: g = 128'h00000000_00000000_00001818_00000000;
                7'h2f: g = 128'h00000000_02060c18_3060c080_00000000;
                7'h30: g = 128'h0000386c_c6c6d6d6_c6c66c38_00000000;
                7'h31: g = 128'h00001838_78181818_1818187e_00000000;
                7'h32: g = 128'h00007cc6_060c1830_60c0c6fe_00000000;
                7'h33: g = 128'h00007cc6_06063c06_0606c67c_00000000;
                7'h34: g = 128'h00000c1c_3c6cccfe_0c0c0c1e_00000000;
                7'h35: g = 128'h0000fec0_c0c0fc06_0606c67c_00000000;
                7'h36: g = 128'h00003860_c0c0fcc6_c6c6c67c_00000000;
                7'h37: g = 128'h0000fec6_06060c18_30303030_00000000;
                7'h38: g = 128'h00007cc6_c6c67cc6_c6c6c67c_00000000;
                7'h39: g = 128'h00007cc6_c6c67e06_06060c78_00000000;
                7'h3a: g = 128'h00000000_18180000_00181800_00000000;
                7'h3b: g = 128'h00000000_18180000_00181830_00000000;
                7'h3c: g = 128'h00000006_0c183060_30180c06_00000000;
                7'h3d: g = 128'h00000000_007e0000_7e000000_00000000;
                7'h3e: g = 128'h00000060_30180c06_0c183060_00000000;
                7'h3f: g = 128'h00007cc6_c60c1818_18001818_00000000;
                7'h40: g = 128'h0000007c_c6c6dede_dedcc07c_00000000;
                7'h41: g = 128'h00001038_6cc6c6fe_c6c6c6c6_00000000;
                7'h42: g = 128'h0000fc66_66667c66_666666fc_00000000;
                7'h43: g = 128'h00003c66_c2c0c0c0_c0c2663c_00000000;
                7'h44: g = 128'h0000f86c_66666666_66666cf8_00000000;
                7'h45: g = 128'h0000fe66_62687868_606266fe_00000000;
                7'h46: g = 128'h0000fe66_62687868_606060f0_00000000;
                7'h47: g = 128'h00003c66_c2c0c0de_c6c6663a_00000000;
                7'h48: g = 128'h0000c6c6_c6c6fec6_c6c6c6c6_00000000;
                7'h49: g = 128'h00003c18_18181818_1818183c_00000000;
                7'h4a: g = 128'h00001e0c_0c0c0c0c_cccccc78_00000000;
                7'h4b: g = 128'h0000e666_666c7878_6c6666e6_00000000;
                7'h4c: g = 128'h0000f060_60606060_606266fe_00000000;
                7'h4d: g = 128'h0000c6ee_fefed6c6_c6c6c6c6_00000000;
                7'h4e: g = 128'h0000c6e6_f6fedece_c6c6c6c6_00000000;
                7'h4f: g = 128'h00007cc6_c6c6c6c6_c6c6c67c_00000000;
                7'h50: g = 128'h0000fc66_66667c60_606060f0_00000000;
                7'h51: g = 128'h00007cc6_c6c6c6c6_c6d6de7c_0c0e0000;
                7'h52: g = 128'h0000fc66_66667c6c_666666e6_00000000;
                7'h53: g = 128'h00007cc6_c660380c_06c6c67c_00000000;
                7'h54: g = 128'h00007e7e_5a181818_1818183c_00000000;
                7'h55: g = 128'h0000c6c6_c6c6c6c6_c6c6c67c_00000000;
                7'h56: g = 128'h0000c6c6_c6c6c6c6_c66c3810_00000000;
                7'h57: g = 128'h0000c6c6_c6c6d6d6_d6feee6c_00000000;
                7'h58: g = 128'h0000c6c6_6c7c3838_7c6cc6c6_00000000;
                7'h59: g = 128'h00006666_66663c18_1818183c_00000000;
                7'h5a: g = 128'h0000fec6_860c1830_60c2c6fe_00000000;
                7'h5b: g = 128'h00003c30_30303030_3030303c_00000000;
                7'h5c: g = 128'h00000080_c0e07038_1c0e0602_00000000;
                7'h5d: g = 128'h00003c0c_0c0c0c0c_0c0c0c3c_00000000;
                7'h5e: g = 128'h10386cc6_00000000_00000000_00000000;
                7'h5f: g = 128'h00000000_00000000_00000000_00ff0000;
                7'h60: g = 128'h30301800_00000000_00000000_00000000;
                7'h61: g = 128'h00000000_00780c7c_cccccc76_00000000;
                7'h62: g = 128'h0000e060_60786c66_6666667c_00000000;
                7'h63: g = 128'h00000000_007cc6c0_c0c0c67c_00000000;
                7'h64: g = 128'h00001c0c_0c3c6ccc_cccccc76_00000000;
                7'h65: g = 128'h00000000_007cc6fe_c0c0c67c_00000000;
                7'h66: g = 128'h00001c36_32307830_30303078_00000000;
                7'h67: g = 128'h00000000_0076cccc_cccccc7c_0ccc7800;
                7'h68: g = 128'h0000e060_606c7666_666666e6_00000000;
                7'h69: g = 128'h00001818_00381818_1818183c_00000000;
                7'h6a: g = 128'h00000606_000e0606_06060606_66663c00;
                7'h6b: g = 128'h0000e060_60666c78_786c66e6_00000000;
                7'h6c: g = 128'h00003818_18181818_1818183c_00000000;
                7'h6d: g = 128'h00000000_00ecfed6_d6d6d6c6_00000000;
                7'h6e: g = 128'h00000000_00dc6666_66666666_00000000;
                7'h6f: g = 128'h00000000_007cc6c6_c6c6c67c_00000000;
                7'h70: g = 128'h00000000_00dc6666_6666667c_6060f000;
                7'h71: g = 128'h00000000_0076cccc_cccccc7c_0c0c1e00;
                7'h72: g = 128'h00000000_00dc7666_606060f0_00000000;
                7'h73: g = 128'h00000000_007cc660_380cc67c_00000000;
                7'h74: g = 128'h00001030_30fc3030_3030361c_00000000;
                7'h75: g = 128'h00000000_00cccccc_cccccc76_00000000;
                7'h76: g = 128'h00000000_00666666_66663c18_00000000;
                7'h77: g = 128'h00000000_00c6c6d6_d6d6fe6c_00000000;
                7'h78: g = 128'h00000000_00c66c38_38386cc6_00000000;
                7'h79: g = 128'h00000000_00c6c6c6_c6c6c67e_060cf800;
                7'h7a: g = 128'h00000000_00fecc18_3060c6fe_00000000;
                7'h7b: g = 128'h00000e18_18187018_1818180e_00000000;
                7'h7c: g = 128'h00001818_18180018_18181818_00000000;
                7'h7d: g = 128'h00007018_18180e18_18181870_00000000;
                7'h7e: g = 128'h000076dc_00000000_00000000_00000000;
                default: g = '0;
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/osd_font_edge_if.sv
// Control-edge and font-lookup signals between the timing generator and osd_font_edge.
interface osd_font_edge_if;
    import osd_pkg::*;

    logic                      async_sig;
    logic                      rise;
    logic                      fall;
    logic [FONT_ADDR_BITS-1:0] char_address;
    logic [FONT_DATA_BITS-1:0] char_q;

    modport master (output async_sig, output char_address,
                    input  rise, input fall, input char_q);
    modport slave  (input  async_sig, input char_address,
                    output rise, output fall, output char_q);
endinterface

// File: rtl/osd_font_edge_sync.sv
// Synchronizer chain plus history flop; rise/fall are decoded from flops only,
// so a level change reaches a pulse SYNC_STAGES edges later and never combinationally.
module sig_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_sig,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] s;
   logic                   p;

   if (SYNC_STAGES < 2) begin : g_bad_depth
      $error("sig_edge_sync needs at least two synchronizer stages");
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s <= '0;
         p <= 1'b0;
      end else begin
         s <= {s[SYNC_STAGES-2:0], async_sig};
         p <= s[SYNC_STAGES-1];
      end
   end

   assign rise =  s[SYNC_STAGES-1] & ~p;
   assign fall = ~s[SYNC_STAGES-1] &  p;

endmodule

// File: rtl/osd_font_edge.sv
// Mode-switch edge detector and registered 8x16 font ROM for the debug overlay.
// The glyph table is built in; FONT_FILE only names the equivalent image for hex-loaded builds.
module osd_font_edge
   import osd_pkg::*;
#(
   parameter int    SYNC_STAGES = 2,
   parameter string FONT_FILE   = "char_rom.hex"
) (
   input  logic       clock,
   input  logic       reset,
   osd_font_edge_if.slave bus
);

   glyph_t                    glyph;
   logic [3:0]                row;
   logic [FONT_DATA_BITS-1:0] row_dat;

   if (FONT_FILE == "") begin : g_bad_font
      $error("osd_font_edge FONT_FILE must name a font image");
   end

   sig_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .clock     (clock),
      .reset     (reset),
      .async_sig (bus.async_sig),
      .rise      (bus.rise),
      .fall      (bus.fall)
   );

   // Row 0 sits in the top byte, so ~row selects byte (15 - row) from the LSB.
   always_comb begin
      glyph   = font_glyph(bus.char_address[FONT_ADDR_BITS-1:4]);
      row     = bus.char_address[3:0];
      row_dat = glyph[{~row, 3'b000} +: FONT_DATA_BITS];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.char_q <= '0;
      end else begin
         bus.char_q <= row_dat;
      end
   end

endmodule

// File: tb/tb_osd_font_edge.sv
// Directed bench for osd_font_edge: reset, edge pulses, glyph rows, asynchronous reset.
module tb_osd_font_edge;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;

   osd_font_edge_if bus ();

   osd_font_edge #(
      .SYNC_STAGES (2),
      .FONT_FILE   ("char_rom.hex")
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_edges(input string tag, input logic exp_rise, input logic exp_fall);
      chk({tag, ".rise"}, {7'd0, bus.rise}, {7'd0, exp_rise});
      chk({tag, ".fall"}, {7'd0, bus.fall}, {7'd0, exp_fall});
   endtask

   // Level was just changed after an edge: quiet, pulse, quiet on the next three edges.
   task automatic expect_pulse(input string tag, input logic exp_rise, input logic exp_fall);
      tick(); chk_edges({tag, "@1"}, 1'b0, 1'b0);
      tick(); chk_edges({tag, "@2"}, exp_rise, exp_fall);
      tick(); chk_edges({tag, "@3"}, 1'b0, 1'b0);
   endtask

   logic [10:0] rom_addr [0:9];
   logic [7:0]  rom_exp  [0:9];

   initial begin
      n_cmp = 0;
      n_err = 0;
      rom_addr[0] = 11'h412; rom_exp[0] = 8'h10;
      rom_addr[1] = 11'h417; rom_exp[1] = 8'hFE;
      rom_addr[2] = 11'h7F5; rom_exp[2] = 8'h00;
      rom_addr[3] = 11'h000; rom_exp[3] = 8'h00;
      rom_addr[4] = 11'h415; rom_exp[4] = 8'hC6;
      rom_addr[5] = 11'h302; rom_exp[5] = 8'h38;
      rom_addr[6] = 11'h4F2; rom_exp[6] = 8'h7C;
      rom_addr[7] = 11'h5FD; rom_exp[7] = 8'hFF;
      rom_addr[8] = 11'h71C; rom_exp[8] = 8'h0C;
      rom_addr[9] = 11'h213; rom_exp[9] = 8'h3C;

      // Reset held with the input already high and a non-blank address applied.
      reset            = 1'b1;
      bus.async_sig    = 1'b1;
      bus.char_address = 11'h417;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_edges("in_reset", 1'b0, 1'b0);
         chk("in_reset.char_q", bus.char_q, 8'h00);
      end
      reset = 1'b0;
      tick(); chk_edges("post_rst@1", 1'b0, 1'b0);
      tick(); chk_edges("post_rst@2", 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(); chk_edges("post_rst_quiet", 1'b0, 1'b0);
      end

      // Toggle: drop, raise and hold for 10 cycles, drop again.
      bus.async_sig = 1'b0;
      expect_pulse("drop0", 1'b0, 1'b1);
      bus.async_sig = 1'b1;
      expect_pulse("raise", 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         tick(); chk_edges("hold_hi", 1'b0, 1'b0);
      end
      bus.async_sig = 1'b0;
      expect_pulse("drop1", 1'b0, 1'b1);

      // One-clock high pulse: rise then fall on consecutive cycles.
      bus.async_sig = 1'b1;
      tick();
      bus.async_sig = 1'b0;
      chk_edges("fast@1", 1'b0, 1'b0);
      tick(); chk_edges("fast@2", 1'b1, 1'b0);
      tick(); chk_edges("fast@3", 1'b0, 1'b1);
      tick(); chk_edges("fast@4", 1'b0, 1'b0);

      // Back-to-back glyph reads, one new address every cycle.
      for (int i = 0; i < 16; i++) begin
         bus.char_address = 11'h200 + 11'(i);
         tick();
         chk("rom_space", bus.char_q, 8'h00);
      end
      for (int i = 0; i < 10; i++) begin
         bus.char_address = rom_addr[i];
         tick();
         chk("rom_vec", bus.char_q, rom_exp[i]);
      end

      // Reset asserted between edges while streaming and during a rise pulse.
      bus.async_sig    = 1'b1;
      bus.char_address = 11'h417;
      tick();
      chk("mid.char_q@1", bus.char_q, 8'hFE);
      bus.char_address = 11'h412;
      tick();
      chk("mid.char_q@2", bus.char_q, 8'h10);
      chk_edges("mid@2", 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst.char_q", bus.char_q, 8'h00);
      chk_edges("async_rst", 1'b0, 1'b0);
      tick();
      chk("held_rst.char_q", bus.char_q, 8'h00);
      chk_edges("held_rst", 1'b0, 1'b0);
      reset = 1'b0;
      tick(); chk_edges("rerelease@1", 1'b0, 1'b0);
      tick(); chk_edges("rerelease@2", 1'b1, 1'b0);
      chk("rerelease.char_q", bus.char_q, 8'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
